// File: rtl/pattern_detector_param.sv
// rtl/pattern_detector_param.sv - parametrised repeating-pattern lock detector with loss-of-lock reporting
// Optional mismatch counter built only when PATDET_ERRCNT_EN is defined.
module pattern_detector_param #(
  parameter int SYM_W    = 8,
  parameter int PAT_SYMS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      restart,
  input  logic [SYM_W-1:0]          sym_in,
  input  logic [SYM_W*PAT_SYMS-1:0] pattern,
  input  logic [CNT_W-1:0]          n,
  output logic                      pattern_valid,
  output logic                      lost,
  output logic [CNT_W-1:0]          match_count,
  output logic [15:0]               err_count
);

  localparam int IDX_W = $clog2(PAT_SYMS);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_sym_idx;
  logic [CNT_W-1:0]   r_match_count;
  logic               r_pattern_valid;
  logic               r_lost;

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_pv_nxt;
  logic               w_lost_nxt;

  logic [SYM_W-1:0]   w_syms [PAT_SYMS];
  logic [SYM_W-1:0]   w_exp;
  logic               w_hit;
  logic               w_first;
  logic               w_last;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [CNT_W-1:0]   w_n_eff;

  for (genvar k = 0; k < PAT_SYMS; k++) begin : g_sym
    assign w_syms[k] = pattern[k*SYM_W +: SYM_W];
  end

  assign w_exp     = w_syms[r_sym_idx];
  assign w_hit     = (sym_in == w_exp);
  assign w_first   = (sym_in == w_syms[0]);
  assign w_last    = (r_sym_idx == IDX_W'(PAT_SYMS - 1));
  assign w_cnt_inc = (r_match_count == {CNT_W{1'b1}}) ? r_match_count : r_match_count + CNT_W'(1);
  assign w_n_eff   = (n == '0) ? CNT_W'(1) : n;

`ifdef PATDET_ERRCNT_EN
  logic [15:0] r_err_count;
  logic [15:0] w_err_nxt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= HUNT;
      r_sym_idx       <= '0;
      r_match_count   <= '0;
      r_pattern_valid <= 1'b0;
      r_lost          <= 1'b0;
`ifdef PATDET_ERRCNT_EN
      r_err_count     <= '0;
`endif
    end else begin
      r_state         <= w_state_nxt;
      r_sym_idx       <= w_idx_nxt;
      r_match_count   <= w_cnt_nxt;
      r_pattern_valid <= w_pv_nxt;
      r_lost          <= w_lost_nxt;
`ifdef PATDET_ERRCNT_EN
      r_err_count     <= w_err_nxt;
`endif
    end
  end

  // >= rather than == so lowering n below an already-reached count still locks at the next wrap
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_sym_idx;
    w_cnt_nxt   = r_match_count;
    w_pv_nxt    = r_pattern_valid;
    w_lost_nxt  = 1'b0;
`ifdef PATDET_ERRCNT_EN
    w_err_nxt   = r_err_count;
`endif
    if (restart) begin
      w_state_nxt = HUNT;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
      w_pv_nxt    = 1'b0;
`ifdef PATDET_ERRCNT_EN
      w_err_nxt   = '0;
`endif
    end else if (enable) begin
      if (w_hit) begin
        if (w_last) begin
          w_idx_nxt = '0;
          w_cnt_nxt = w_cnt_inc;
          if (r_state == HUNT && w_cnt_inc >= w_n_eff) begin
            w_state_nxt = LOCKED;
            w_pv_nxt    = 1'b1;
          end
        end else begin
          w_idx_nxt = r_sym_idx + IDX_W'(1);
        end
      end else begin
        w_cnt_nxt = '0;
        w_idx_nxt = w_first ? IDX_W'(1) : '0;
`ifdef PATDET_ERRCNT_EN
        if (r_err_count != 16'hFFFF) w_err_nxt = r_err_count + 16'd1;
`endif
        if (r_state == LOCKED) begin
          w_state_nxt = HUNT;
          w_pv_nxt    = 1'b0;
          w_lost_nxt  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pattern_valid = r_pattern_valid;
    lost          = r_lost;
    match_count   = r_match_count;
`ifdef PATDET_ERRCNT_EN
    err_count     = r_err_count;
`else
    err_count     = 16'h0000;
`endif
  end

endmodule

// File: tb/tb_pattern_detector_param.sv
// tb/tb_pattern_detector_param.sv - directed self-checking bench for pattern_detector_param
module tb_pattern_detector_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        restart;
  logic [7:0]  sym_in;
  logic [31:0] pattern;
  logic [7:0]  n;
  logic        pattern_valid;
  logic        lost;
  logic [7:0]  match_count;
  logic [15:0] err_count;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  logic [7:0] clean [4] = '{8'h1E, 8'h49, 8'hCF, 8'h3A};
  logic [7:0] sym;

  pattern_detector_param #(.SYM_W(8), .PAT_SYMS(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .restart(restart),
    .sym_in(sym_in), .pattern(pattern), .n(n),
    .pattern_valid(pattern_valid), .lost(lost),
    .match_count(match_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [7:0] s);
    sym_in = s;
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic idle();
    enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; restart = 1'b0; sym_in = 8'h00;
    pattern = 32'h3ACF491E; n = 8'd4;
    #12;
    check("reset_pv",  {31'd0, pattern_valid}, 32'd0);
    check("reset_lost", {31'd0, lost}, 32'd0);
    check("reset_mc",  {24'd0, match_count}, 32'd0);
    check("reset_err", {16'd0, err_count}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // 1: four clean repeats lock on the 16th symbol
    for (int i = 0; i < 15; i++) feed(clean[i % 4]);
    check("t1_pv_before", {31'd0, pattern_valid}, 32'd0);
    check("t1_mc_before", {24'd0, match_count}, 32'd3);
    feed(8'h3A);
    check("t1_pv", {31'd0, pattern_valid}, 32'd1);
    check("t1_mc", {24'd0, match_count}, 32'd4);
    check("t1_lost", {31'd0, lost}, 32'd0);
    idle();
    check("t1_hold_pv", {31'd0, pattern_valid}, 32'd1);
    check("t1_hold_mc", {24'd0, match_count}, 32'd4);
    for (int i = 0; i < 4; i++) feed(clean[i]);
    check("t1_mc5", {24'd0, match_count}, 32'd5);

    // 3: mismatch while locked
    feed(8'h1E); feed(8'h49);
    check("t3_mc_mid", {24'd0, match_count}, 32'd5);
    feed(8'hAA);
    check("t3_lost", {31'd0, lost}, 32'd1);
    check("t3_pv", {31'd0, pattern_valid}, 32'd0);
    check("t3_mc", {24'd0, match_count}, 32'd0);
    idle();
    check("t3_lost_pulse", {31'd0, lost}, 32'd0);

    // 2: one byte position corrupted in every repeat
    for (int b = 0; b < 4; b++) begin
      do_restart();
      for (int r = 0; r < 4; r++) begin
        for (int i = 0; i < 4; i++) begin
          sym = (i == b) ? 8'hAA : clean[i];
          feed(sym);
        end
        check($sformatf("t2_mc_b%0d_r%0d", b, r), {24'd0, match_count}, 32'd0);
      end
      check($sformatf("t2_pv_b%0d", b), {31'd0, pattern_valid}, 32'd0);
    end

    // 4: repeated first symbol resyncs
    do_restart();
    feed(8'h1E); feed(8'h1E); feed(8'h49); feed(8'hCF); feed(8'h3A);
    check("t4_mc1", {24'd0, match_count}, 32'd1);
    for (int i = 0; i < 11; i++) feed(clean[i % 4]);
    check("t4_pv_before", {31'd0, pattern_valid}, 32'd0);
    feed(8'h3A);
    check("t4_pv", {31'd0, pattern_valid}, 32'd1);
    check("t4_mc", {24'd0, match_count}, 32'd4);

    // 5: restart from LOCKED, then n=0 locks after one repeat
    do_restart();
    check("t5_rs_pv", {31'd0, pattern_valid}, 32'd0);
    check("t5_rs_mc", {24'd0, match_count}, 32'd0);
    n = 8'd0;
    feed(8'h1E); feed(8'h49); feed(8'hCF);
    check("t5_pv_before", {31'd0, pattern_valid}, 32'd0);
    feed(8'h3A);
    check("t5_pv", {31'd0, pattern_valid}, 32'd1);
    check("t5_mc", {24'd0, match_count}, 32'd1);
    feed(8'h1E); feed(8'h49);
    restart = 1'b1; sym_in = 8'hAA; enable = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0; enable = 1'b0;
    check("t5_rm_lost", {31'd0, lost}, 32'd0);
    check("t5_rm_pv", {31'd0, pattern_valid}, 32'd0);
    check("t5_rm_mc", {24'd0, match_count}, 32'd0);
    check("t5_rm_err", {16'd0, err_count}, 32'd0);

    // lowering n below the current count in HUNT
    n = 8'd4;
    for (int i = 0; i < 8; i++) feed(clean[i % 4]);
    check("tn_pv_before", {31'd0, pattern_valid}, 32'd0);
    n = 8'd1;
    for (int i = 0; i < 4; i++) feed(clean[i]);
    check("tn_pv", {31'd0, pattern_valid}, 32'd1);
    check("tn_mc", {24'd0, match_count}, 32'd3);
    n = 8'd4;

    // 6: error counter
    do_restart();
    for (int i = 0; i < 5; i++) feed(8'hAA);
`ifdef PATDET_ERRCNT_EN
    check("t6_err5", {16'd0, err_count}, 32'd5);
    #2 rst = 1'b0;
    #1;
    check("t6_async_err", {16'd0, err_count}, 32'd0);
    @(negedge clk); rst = 1'b1;
`else
    check("t6_err_tied", {16'd0, err_count}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
